// File: rtl/rom_boot_sequencer.sv
// rom_boot_sequencer: copies WORD_COUNT words from a synchronous word source
// into the SoC ROM through the rom_loader handshake. The Hack CPU is held in
// reset until the image is loaded plus a programmable hold time.
//
// Handshake (one word): rom_loader_data is set up first. rom_loader_load
// rises together with a rom_loader_sck pulse (SCK_HALF_CYCLES high, then
// SCK_HALF_CYCLES low). The sequencer then waits for rom_loader_ack high,
// drops load, and waits for ack low before moving on. Both ack edges are
// bounded by ACK_TIMEOUT cycles. A missed edge retries the same word, up to
// MAX_RETRIES times, before a sticky ERROR. rom_loader_data does not change
// between PRESENT and the end of RELEASE.
//
// Optional build macro ROM_BOOT_CHECKSUM_EN adds checksum_expected and
// rejects the image (ERROR) when the modular sum of accepted words differs.
module rom_boot_sequencer #(
  parameter int DATA_WIDTH        = 16,
  parameter int ADDR_WIDTH        = 16,
  parameter int WORD_COUNT        = 973,
  parameter int SCK_HALF_CYCLES   = 1,
  parameter int ACK_TIMEOUT       = 1023,
  parameter int MAX_RETRIES       = 3,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  reload,
  input  logic                  user_hold,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  rom_loader_load,
  output logic                  rom_loader_sck,
  output logic [DATA_WIDTH-1:0] rom_loader_data,
  input  logic                  rom_loader_ack,
`ifdef ROM_BOOT_CHECKSUM_EN
  input  logic [DATA_WIDTH-1:0] checksum_expected,
`endif
  output logic                  hack_external_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] word_index,
  output logic [3:0]            dbg_state
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_PRESENT  = 4'd2;
  localparam logic [3:0] ST_SCK_HI   = 4'd3;
  localparam logic [3:0] ST_SCK_LO   = 4'd4;
  localparam logic [3:0] ST_WAIT_ACK = 4'd5;
  localparam logic [3:0] ST_RELEASE  = 4'd6;
  localparam logic [3:0] ST_RETRY    = 4'd7;
  localparam logic [3:0] ST_HOLD     = 4'd8;
  localparam logic [3:0] ST_DONE     = 4'd9;
  localparam logic [3:0] ST_ERROR    = 4'd10;

  // One shared phase timer covers sck phases, ack timeouts, retry gap and hold.
  localparam int T_A   = (ACK_TIMEOUT > SCK_HALF_CYCLES) ? ACK_TIMEOUT : SCK_HALF_CYCLES;
  localparam int T_B   = (T_A > RESET_HOLD_CYCLES) ? T_A : RESET_HOLD_CYCLES;
  localparam int TMR_W = $clog2(T_B + 2) + 1;
  localparam int RTY_W = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [TMR_W-1:0]      SCK_LAST  = TMR_W'(SCK_HALF_CYCLES - 1);
  localparam logic [TMR_W-1:0]      ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]      HOLD_LAST = TMR_W'((RESET_HOLD_CYCLES > 0) ? RESET_HOLD_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0]      RTY_GAP   = TMR_W'(2);
  localparam logic [RTY_W-1:0]      RTY_MAX   = RTY_W'(MAX_RETRIES);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(WORD_COUNT - 1);
  localparam logic [3:0]            ST_AFTER_LAST = (RESET_HOLD_CYCLES == 0) ? ST_DONE : ST_HOLD;

  logic [3:0]            r_state;
  logic [TMR_W-1:0]      r_timer;
  logic [RTY_W-1:0]      r_retry;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_load;
  logic                  r_sck;

`ifdef ROM_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;
  logic [DATA_WIDTH-1:0] w_sum_next;
  assign w_sum_next = r_sum + r_data;
`endif

  assign src_addr            = r_index;
  assign word_index          = r_index;
  assign rom_loader_load     = r_load;
  assign rom_loader_sck      = r_sck;
  assign rom_loader_data     = r_data;
  assign done                = (r_state == ST_DONE);
  assign error               = (r_state == ST_ERROR);
  assign hack_external_reset = (r_state != ST_DONE) | user_hold;
  assign dbg_state           = r_state;

  // Boot FSM: sequences fetch, strobe, ack handshake, retries and reset hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_retry <= '0;
      r_index <= '0;
      r_data  <= '0;
      r_load  <= 1'b0;
      r_sck   <= 1'b0;
`ifdef ROM_BOOT_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else if (reload) begin
      // Reload overrides whatever the current state would do this cycle.
      r_state <= ST_FETCH;
      r_timer <= '0;
      r_retry <= '0;
      r_index <= '0;
      r_load  <= 1'b0;
      r_sck   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_index <= '0;
            r_timer <= '0;
          end
        end
        ST_FETCH: begin
`ifdef ROM_BOOT_CHECKSUM_EN
          if (r_index == '0) r_sum <= '0;
`endif
          // First cycle presents the address, second captures the source word.
          if (r_timer == '0) begin
            r_timer <= TMR_W'(1);
          end else begin
            r_data  <= src_data;
            r_timer <= '0;
            r_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // A stale ack from the previous word must clear before a new request.
          if (!rom_loader_ack) begin
            r_load  <= 1'b1;
            r_sck   <= 1'b1;
            r_timer <= '0;
            r_state <= ST_SCK_HI;
          end else if (r_timer == ACK_LAST) begin
            r_timer <= '0;
            r_state <= ST_RETRY;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_SCK_HI: begin
          if (r_timer == SCK_LAST) begin
            r_sck   <= 1'b0;
            r_timer <= '0;
            r_state <= ST_SCK_LO;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_SCK_LO: begin
          if (r_timer == SCK_LAST) begin
            r_timer <= '0;
            r_state <= ST_WAIT_ACK;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (rom_loader_ack) begin
            r_load  <= 1'b0;
            r_timer <= '0;
            r_state <= ST_RELEASE;
          end else if (r_timer == ACK_LAST) begin
            r_load  <= 1'b0;
            r_timer <= '0;
            r_state <= ST_RETRY;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!rom_loader_ack) begin
            r_retry <= '0;
            r_timer <= '0;
`ifdef ROM_BOOT_CHECKSUM_EN
            r_sum   <= w_sum_next;
`endif
            if (r_index == LAST_IDX) begin
`ifdef ROM_BOOT_CHECKSUM_EN
              if (w_sum_next != checksum_expected) r_state <= ST_ERROR;
              else
`endif
              r_state <= ST_AFTER_LAST;
            end else begin
              r_index <= r_index + ADDR_WIDTH'(1);
              r_state <= ST_FETCH;
            end
          end else if (r_timer == ACK_LAST) begin
            r_timer <= '0;
            r_state <= ST_RETRY;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_RETRY: begin
          // First cycle decides retry vs. give up; then a short quiet gap.
          if (r_timer == '0) begin
            if (r_retry == RTY_MAX) begin
              r_state <= ST_ERROR;
            end else begin
              r_retry <= r_retry + RTY_W'(1);
              r_timer <= TMR_W'(1);
            end
          end else if (r_timer == RTY_GAP) begin
            r_timer <= '0;
            r_state <= ST_PRESENT;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_timer == HOLD_LAST) begin
            r_timer <= '0;
            r_state <= ST_DONE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_DONE: begin
          r_load <= 1'b0;
        end
        ST_ERROR: begin
          r_load <= 1'b0;
          r_sck  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_boot_sequencer.sv
// Testbench for rom_boot_sequencer: BRAM source model, rom_loader responder
// with scripted ack misses, and a scoreboard of expected load-pulse data.
module tb_rom_boot_sequencer;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int WC   = 4;
  localparam int SCKH = 1;
  localparam int ATO  = 8;
  localparam int MAXR = 3;
  localparam int HOLD = 16;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, reload, user_hold, ack;
  logic [AW-1:0] src_addr, word_index;
  logic [DW-1:0] src_data, ld_data;
  logic          load, sck, hack, done, error;
  logic [3:0]    dbg_state;

  rom_boot_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_COUNT(WC), .SCK_HALF_CYCLES(SCKH),
    .ACK_TIMEOUT(ATO), .MAX_RETRIES(MAXR), .RESET_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .reload(reload),
    .user_hold(user_hold), .src_addr(src_addr), .src_data(src_data),
    .rom_loader_load(load), .rom_loader_sck(sck), .rom_loader_data(ld_data),
    .rom_loader_ack(ack), .hack_external_reset(hack), .done(done),
    .error(error), .word_index(word_index), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- source memory model ----------------
  logic [DW-1:0] img [WC];
  always @(posedge clk) src_data <= img[src_addr[1:0]];

  // ---------------- responder ----------------
  int miss [WC];     // acks to withhold for each word before answering
  int seen [WC];
  int ack_dly = 2;
  int gen = 0;       // bumped by the bench to restart the responder
  int my_gen = 0;
  int rs = 0;
  int cnt = 0;
  int widx = 0;
  int last_ack_fall = 0;

  initial begin
    ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || gen != my_gen) begin
        ack = 1'b0; rs = 0; my_gen = gen;
        for (int i = 0; i < WC; i++) seen[i] = 0;
      end else begin
        case (rs)
          0: if (load && sck) begin
               widx = int'(word_index[1:0]);
               if (seen[widx] < miss[widx]) rs = 3;
               else begin rs = 1; cnt = ack_dly; end
               seen[widx]++;
             end
          1: if (cnt <= 1) begin ack = 1'b1; rs = 2; cnt = ack_dly; end else cnt--;
          2: if (!load) begin
               if (cnt <= 1) begin ack = 1'b0; rs = 0; last_ack_fall = cyc; end
               else cnt--;
             end
          3: if (!load) rs = 0;
          default: rs = 0;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  bit   exp_err;
  int   exp_err_idx;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rst_fall = 0;
  logic mon_prev_load = 1'b0;
  logic mon_prev_hack = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of load must carry the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (load && !mon_prev_load) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL spurious_load: load pulse with data 0x%0h, none expected", ld_data);
        end else begin
          check("load_data", ld_data, exp_q.pop_front());
        end
      end
      if (mon_prev_hack && !hack) rst_fall = cyc;
      mon_prev_load = load;
      mon_prev_hack = hack;
    end
  end

  // Reference model: each word is presented once plus once per withheld ack;
  // a word missing more than MAX_RETRIES acks is presented MAX_RETRIES+1 times
  // and the load ends in error on that word.
  task automatic prepare();
    exp_q.delete();
    exp_err = 1'b0;
    exp_err_idx = 0;
    gen++;
    for (int i = 0; i < WC; i++) begin
      if (miss[i] > MAXR) begin
        for (int a = 0; a <= MAXR; a++) exp_q.push_back(img[i]);
        exp_err = 1'b1;
        exp_err_idx = i;
        break;
      end
      for (int a = 0; a <= miss[i]; a++) exp_q.push_back(img[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input bit via_reload);
    if (via_reload) begin
      reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
    end else begin
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
    end
  endtask

  task automatic finish_check(input string name);
    int k;
    for (k = 0; k < 4000 && !(done || error); k++) begin @(posedge clk); #1; end
    if (!(done || error)) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: neither done nor error after %0d cycles", name, k);
    end
    repeat (2) begin @(posedge clk); #1; end
    check({name, "_done"}, 32'(done), 32'(!exp_err));
    check({name, "_error"}, 32'(error), 32'(exp_err));
    check({name, "_cpu_reset"}, 32'(hack), 32'(exp_err));
    check({name, "_pulses_left"}, 32'(exp_q.size()), 0);
    if (exp_err) check({name, "_err_index"}, 32'(word_index), 32'(exp_err_idx));
    // One cycle to observe ack low, then RESET_HOLD_CYCLES in hold.
    else check({name, "_hold_cycles"}, 32'(rst_fall - last_ack_fall), 32'(HOLD + 1));
  endtask

  task automatic clear_miss();
    for (int i = 0; i < WC; i++) miss[i] = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; reload = 1'b0; user_hold = 1'b0;
    clear_miss();
    for (int i = 0; i < WC; i++) img[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_load", 32'(load), 0);
    check("rst_sck", 32'(sck), 0);
    check("rst_data", 32'(ld_data), 0);
    check("rst_src_addr", 32'(src_addr), 0);
    check("rst_word_index", 32'(word_index), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_cpu_reset", 32'(hack), 1);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_load", 32'(load), 0);

    // Basic image via start
    img[0] = 16'h1111; img[1] = 16'h2222; img[2] = 16'h3333; img[3] = 16'h4444;
    ack_dly = 2;
    prepare();
    launch(1'b0);
    finish_check("basic");

    // start is ignored once loaded
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    check("done_ignores_start", 32'(done), 1);
    check("done_ignores_start_load", 32'(load), 0);

    // user_hold while DONE
    user_hold = 1'b1;
    @(posedge clk); #1;
    check("user_hold_cpu_reset", 32'(hack), 1);
    check("user_hold_done", 32'(done), 1);
    user_hold = 1'b0;
    @(posedge clk); #1;
    check("user_hold_release", 32'(hack), 0);

    // Word 2 never acknowledged
    clear_miss(); miss[2] = 100;
    prepare();
    launch(1'b1);
    finish_check("timeout");

    // Word 1 misses one ack
    clear_miss(); miss[1] = 1;
    prepare();
    launch(1'b1);
    finish_check("transient");

    // Reload during SCK_HI of word 2
    clear_miss();
    for (int i = 0; i < WC; i++) img[i] = DW'($urandom_range(1, 16'hFFFF));
    prepare();
    launch(1'b1);
    begin
      int k;
      for (k = 0; k < 500 && !(word_index == 2 && sck); k++) begin @(posedge clk); #1; end
      if (!(word_index == 2 && sck)) begin
        n_cmp++; n_fail++;
        $display("FAIL reload_wait: word 2 strobe not seen after %0d cycles", k);
      end
    end
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload_load_low", 32'(load), 0);
    check("reload_sck_low", 32'(sck), 0);
    check("reload_src_addr", 32'(src_addr), 0);
    check("reload_done_low", 32'(done), 0);
    prepare();
    finish_check("reload");

    // Asynchronous reset while waiting for ack on word 1
    clear_miss(); miss[1] = 100;
    img[1] = 16'hBEEF;
    ack_dly = 1;
    prepare();
    launch(1'b1);
    begin
      int k;
      for (k = 0; k < 500 && !(word_index == 1 && load); k++) begin @(posedge clk); #1; end
      if (!(word_index == 1 && load)) begin
        n_cmp++; n_fail++;
        $display("FAIL reset_wait: word 1 load not seen after %0d cycles", k);
      end
    end
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_load", 32'(load), 0);
    check("async_rst_sck", 32'(sck), 0);
    check("async_rst_data", 32'(ld_data), 0);
    check("async_rst_src_addr", 32'(src_addr), 0);
    check("async_rst_word_index", 32'(word_index), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_error", 32'(error), 0);
    check("async_rst_cpu_reset", 32'(hack), 1);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle_load", 32'(load), 0);

    // Randomised images, ack delays and ack-miss patterns
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < WC; i++) begin
        img[i]  = DW'($urandom_range(0, 16'hFFFF));
        miss[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      end
      ack_dly = int'($urandom_range(1, 3));
      prepare();
      launch(1'b1);
      finish_check($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
